// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the MMIO bridge: address map, command FIFO sizing
// and the address decoder used by the top level.
package mmio_bridge_pkg;

    // Value of addr[31] that selects the data RAM.
    localparam logic        RAM_ADDR_MSB      = 1'b0;
    // GPU command window, word-aligned, inclusive limits.
    localparam logic [31:0] CMD_BASE          = 32'h8000_0000;
    localparam logic [31:0] CMD_LIMIT         = 32'h8000_00FC;
    // Single status/control register.
    localparam logic [31:0] STATUS_ADDR       = 32'h8000_0100;

    // Command FIFO sizing.
    localparam int          DEFAULT_CMD_DEPTH = 4;
    localparam int          CMD_ADDR_W        = 6;
    localparam int          CMD_DATA_W        = 32;
    localparam int          CMD_ENTRY_W       = CMD_ADDR_W + CMD_DATA_W;

    // Bit position of the sticky error flag inside the status word.
    localparam int          STATUS_ERR_BIT    = 8;

    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_CMD      = 2'd1,
        REGION_STATUS   = 2'd2,
        REGION_UNMAPPED = 2'd3
    } region_e;

    // Classify a byte address; the two low bits never take part.
    function automatic region_e decode_region(input logic [31:0] addr);
        logic [31:0] word_addr;
        region_e     region;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr[31] == RAM_ADDR_MSB) begin
            region = REGION_RAM;
        end else if ((word_addr >= CMD_BASE) && (word_addr <= CMD_LIMIT)) begin
            region = REGION_CMD;
        end else if (word_addr == STATUS_ADDR) begin
            region = REGION_STATUS;
        end else begin
            region = REGION_UNMAPPED;
        end
        return region;
    endfunction

endpackage

// File: rtl/mmio_bridge_cmd_fifo.sv
// Command FIFO between the CPU store path and the GPU command stream.
// Head entry is read combinationally so a push is visible one cycle later.
// Pushes are refused while full even if a pop happens in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full check uses the registered count, so a pop cannot free a slot for a same-cycle push.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset only invalidates, storage is left as is.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Memory-stage MMIO bridge: routes loads/stores to the data RAM, a GPU
// command FIFO and a status register, and stalls the pipeline on a full FIFO.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int CMD_DEPTH = DEFAULT_CMD_DEPTH
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_write_m_i,
    input  logic        mem_read_m_i,
    input  logic [31:0] addr_m_i,
    input  logic [31:0] write_data_m_i,
    output logic [31:0] read_data_m_o,
    output logic        stall_m_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [5:0]  cmd_addr_o,
    output logic [31:0] cmd_data_o
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    region_e                region;
    logic                   is_store;
    logic                   is_load;
    logic                   cmd_store;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [CMD_ENTRY_W-1:0] fifo_head;
    logic [31:0]            status_word;
    logic                   err_q;
    logic                   err_d;
    logic                   err_set;
    logic                   err_clr;

    assign region    = decode_region(addr_m_i);
    // A cycle with both strobes high behaves as a store only.
    assign is_store  = mem_write_m_i;
    assign is_load   = mem_read_m_i & ~mem_write_m_i;
    assign cmd_store = is_store & (region == REGION_CMD);

    // Data RAM port is a straight pass-through with a gated write enable.
    assign ram_we_o    = is_store & (region == REGION_RAM);
    assign ram_addr_o  = addr_m_i;
    assign ram_wdata_o = write_data_m_i;

    // A CMD store into a full FIFO holds the pipeline and is retried next cycle.
    assign fifo_push = cmd_store & ~fifo_full;
    assign stall_m_o = cmd_store & fifo_full;
    assign fifo_pop  = ~fifo_empty & cmd_ready_i;

    cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_ENTRY_W)
    ) u_cmd_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fifo_push),
        .push_data_i ({addr_m_i[7:2], write_data_m_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign cmd_valid_o = ~fifo_empty;
    assign cmd_addr_o  = fifo_head[CMD_ENTRY_W-1 -: CMD_ADDR_W];
    assign cmd_data_o  = fifo_head[CMD_DATA_W-1:0];

    // Status word: empty, full, occupancy and the sticky error flag.
    always_comb begin
        status_word                 = '0;
        status_word[0]              = fifo_empty;
        status_word[1]              = fifo_full;
        status_word[2 +: CNT_W]     = fifo_count;
        status_word[STATUS_ERR_BIT] = err_q;
    end

    // Load data mux by region; CMD and unmapped read back as zero.
    always_comb begin
        read_data_m_o = '0;
        case (region)
            REGION_RAM:    read_data_m_o = ram_rdata_i;
            REGION_STATUS: read_data_m_o = status_word;
            default:       read_data_m_o = '0;
        endcase
    end

    // Sticky error: set on bad accesses, cleared by any STATUS store, set has priority.
    always_comb begin
        err_set = (is_store & (region == REGION_UNMAPPED)) |
                  (is_load & ((region == REGION_UNMAPPED) | (region == REGION_CMD)));
        err_clr = is_store & (region == REGION_STATUS);
        err_d   = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule
